ac_mode_sequencer: RTL
======================

Name: ac_mode_sequencer

Overview:
- Sequences the air-conditioner operating mode (0..4) that drives the fan-speed and 7-segment decode logic.
- Arbitrates between manual up/down button requests and an automatic thermostat request to form a target mode.
- Ramps the live mode one step at a time toward the target, with a minimum dwell time between steps.
- Enforces a compressor anti-short-cycle lockout after every transition to OFF.

Parameters:
- MAX_MODE, 4: highest legal mode code.
- DWELL_CYCLES, 1000: clk cycles held after each mode step before the next step; must be >= 1.
- MIN_OFF_CYCLES, 5000: clk cycles mode must stay 0 after a 1->0 transition before it may leave 0; must be >= 1.
- TEMP_W, 8: width of the unsigned temperature inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- power_en  in  1  master switch; 0 forces target 0.
- auto_en  in  1  1 = thermostat sets target; 0 = buttons set target.
- btn_up  in  1  single-cycle pulse, request target +1 (manual only).
- btn_dn  in  1  single-cycle pulse, request target -1 (manual only).
- temp_cur  in  TEMP_W  measured temperature, unsigned.
- temp_set  in  TEMP_W  setpoint temperature, unsigned.
- mode  out  3  live mode, 0..MAX_MODE; feeds fan/display decode.
- target  out  3  registered target mode.
- step_pulse  out  1  high for one cycle on each cycle where mode changes.
- busy  out  1  high while in S_DWELL, or while target != mode.
- lockout  out  1  high while the min-off counter is nonzero.

Behaviour:
- Reset (async): mode=0, target=0, state=S_STEADY, dwell_cnt=0, lock_cnt=0, step_pulse=0. No lockout is active out of reset.
- Target register, updated every clk:
  - power_en=0: target <= 0.
  - power_en=1, auto_en=1: target <= f(d), where d = temp_cur - temp_set computed signed at TEMP_W+1 bits.
    - d<=0 -> 0; 1..2 -> 1; 3..4 -> 2; 5..6 -> 3; >=7 -> 4.
    - Result is then clamped to MAX_MODE.
  - power_en=1, auto_en=0:
    - btn_up alone: target+1, saturating at MAX_MODE.
    - btn_dn alone: target-1, saturating at 0.
    - Both buttons in the same cycle: no change.
  - Buttons are ignored while auto_en=1.
- FSM states: S_STEADY, S_DWELL.
  - S_STEADY with target==mode: hold.
  - S_STEADY with target!=mode, blocked case: mode==0, target>0 and lock_cnt!=0 -> hold (busy=1).
  - S_STEADY with target!=mode, otherwise:
    - mode steps by exactly 1 toward target; step_pulse=1.
    - dwell_cnt <= DWELL_CYCLES-1; go to S_DWELL.
  - S_DWELL: decrement dwell_cnt each cycle; when it is 0, return to S_STEADY. Target changes during dwell are tracked but not applied until back in S_STEADY.
- Latency: button pulse at edge n -> target updated at n+1 -> mode steps at n+2 (if not blocked). Successive steps are DWELL_CYCLES+1 cycles apart.
- Lockout:
  - On the edge where mode goes 1->0, lock_cnt <= MIN_OFF_CYCLES.
  - Otherwise lock_cnt decrements while nonzero.
  - Earliest 0->1 step is MIN_OFF_CYCLES+1 cycles after the step to 0.
- power_en falling mid-ramp: the ramp-down obeys dwell like any other change; there is no instantaneous drop.
- Reset mid-ramp or mid-lockout: returns immediately to the reset state; the lockout is cleared.
- Mode never leaves 0..MAX_MODE; an illegal internal mode value forces mode=0 on the next edge.

Optional Feature:
- Macro: SMARTAC_ECO_EN.
- When defined:
  - Adds input eco (1 bit).
  - While eco=1, target is capped at MAX_MODE-1 after all other rules.
  - If mode exceeds the cap, it ramps down under the normal dwell rule.
- When undefined: no eco port and no cap.

Decomposition:
- Package smart_ac_pkg:
  - MODE_OFF=0, MODE_MAX=4.
  - Fan codes OFF/LOW/MEDIUM/HIGH.
  - FSM state typedef {S_STEADY, S_DWELL}.
  - Temperature band thresholds 0/2/4/6.
- Sub-module ac_temp_to_mode: combinational signed-difference to target-mode mapping, reused by future display/telemetry blocks.

Test Plan (DWELL_CYCLES=4, MIN_OFF_CYCLES=8):
- Reset, power_en=1, auto_en=0, three btn_up pulses 1 cycle apart:
  - target reaches 3.
  - mode goes 0->1->2->3 with steps 5 cycles apart.
  - step_pulse fires 3 times; busy drops after the last dwell.
- Manual at mode 4, btn_up -> target stays 4. At target 0, btn_dn -> stays 0. btn_up+btn_dn same cycle -> target unchanged.
- auto_en=1, temp_set=20, temp_cur=27:
  - target=4; mode ramps to 4.
  - temp_cur=21 -> target=1; mode ramps down 4->3->2->1 with 5-cycle spacing.
- Mode 1, power_en=0:
  - mode->0 and lockout=1 for 8 cycles.
  - power_en=1 with btn_up during lockout -> mode holds 0; it steps to 1 on the first cycle after lockout clears.
- rst asserted mid-dwell at mode 2, async between edges:
  - mode, target, lockout and step_pulse clear immediately.
  - After release, no lockout blocks a btn_up step.
- SMARTAC_ECO_EN build, auto target 4, eco=1 -> target 3. eco asserted at mode 4 -> ramps to 3 after dwell.

Source files
------------

// File: rtl/smart_ac_pkg.sv
// rtl/smart_ac_pkg.sv - shared mode, fan, FSM and temperature band definitions for the smart AC blocks
package smart_ac_pkg;

    localparam int MODE_OFF = 0;
    localparam int MODE_MAX = 4;

    typedef enum logic [1:0] {
        FAN_OFF,
        FAN_LOW,
        FAN_MEDIUM,
        FAN_HIGH
    } fan_e;

    typedef enum logic {
        S_STEADY,
        S_DWELL
    } state_e;

    // Upper bounds of the temperature-difference bands for modes 0..3;
    // anything above the last band maps to the top mode.
    localparam int TEMP_BAND_0 = 0;
    localparam int TEMP_BAND_1 = 2;
    localparam int TEMP_BAND_2 = 4;
    localparam int TEMP_BAND_3 = 6;

    // One mode step from cur toward tgt; caller guarantees cur != tgt.
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        return (tgt > cur) ? cur + 3'd1 : cur - 3'd1;
    endfunction

endpackage

// File: rtl/ac_temp_to_mode.sv
// rtl/ac_temp_to_mode.sv - combinational temperature difference to target mode mapping
module ac_temp_to_mode
    import smart_ac_pkg::*;
#(
    parameter int TEMP_W   = 8,
    parameter int MAX_MODE = MODE_MAX
) (
    input  logic [TEMP_W-1:0] temp_cur_i,
    input  logic [TEMP_W-1:0] temp_set_i,
    output logic [2:0]        mode_o
);

    localparam logic [2:0]          MAX_M = 3'(MAX_MODE);
    localparam logic signed [TEMP_W:0] BAND0 = (TEMP_W+1)'(TEMP_BAND_0);
    localparam logic signed [TEMP_W:0] BAND1 = (TEMP_W+1)'(TEMP_BAND_1);
    localparam logic signed [TEMP_W:0] BAND2 = (TEMP_W+1)'(TEMP_BAND_2);
    localparam logic signed [TEMP_W:0] BAND3 = (TEMP_W+1)'(TEMP_BAND_3);

    // One extra bit so a setpoint above the measurement goes negative instead of wrapping.
    logic signed [TEMP_W:0] diff;
    logic [2:0]             raw_mode;

    assign diff = $signed({1'b0, temp_cur_i}) - $signed({1'b0, temp_set_i});

    // Band lookup followed by a clamp to the configured top mode.
    always_comb begin
        raw_mode = 3'd0;
        if (diff > BAND3) begin
            raw_mode = 3'd4;
        end else if (diff > BAND2) begin
            raw_mode = 3'd3;
        end else if (diff > BAND1) begin
            raw_mode = 3'd2;
        end else if (diff > BAND0) begin
            raw_mode = 3'd1;
        end
        mode_o = (raw_mode > MAX_M) ? MAX_M : raw_mode;
    end

endmodule

// File: rtl/ac_mode_sequencer.sv
// rtl/ac_mode_sequencer.sv - AC mode ramp sequencer with dwell and anti-short-cycle lockout; SMARTAC_ECO_EN adds an eco cap input
module ac_mode_sequencer
    import smart_ac_pkg::*;
#(
    parameter int MAX_MODE       = MODE_MAX,
    parameter int DWELL_CYCLES   = 1000,
    parameter int MIN_OFF_CYCLES = 5000,
    parameter int TEMP_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_en,
    input  logic              auto_en,
    input  logic              btn_up,
    input  logic              btn_dn,
`ifdef SMARTAC_ECO_EN
    input  logic              eco,
`endif
    input  logic [TEMP_W-1:0] temp_cur,
    input  logic [TEMP_W-1:0] temp_set,
    output logic [2:0]        mode,
    output logic [2:0]        target,
    output logic              step_pulse,
    output logic              busy,
    output logic              lockout
);

    localparam int         DW    = $clog2(DWELL_CYCLES + 1);
    localparam int         LW    = $clog2(MIN_OFF_CYCLES + 1);
    localparam logic [2:0] MAX_M = 3'(MAX_MODE);
    localparam logic [2:0] OFF_M = 3'(MODE_OFF);

    state_e        state_q;
    logic [2:0]    mode_q;
    logic [2:0]    target_q;
    logic [2:0]    target_d;
    logic [DW-1:0] dwell_q;
    logic [LW-1:0] lock_q;
    logic          step_q;
    logic [2:0]    auto_mode;
    logic          blocked;

    ac_temp_to_mode #(
        .TEMP_W   (TEMP_W),
        .MAX_MODE (MAX_MODE)
    ) u_temp_to_mode (
        .temp_cur_i (temp_cur),
        .temp_set_i (temp_set),
        .mode_o     (auto_mode)
    );

    // Target arbitration: power switch, then thermostat, then buttons, then eco cap.
    always_comb begin
        target_d = target_q;
        if (!power_en) begin
            target_d = OFF_M;
        end else if (auto_en) begin
            target_d = auto_mode;
        end else if (btn_up && !btn_dn) begin
            target_d = (target_q >= MAX_M) ? MAX_M : target_q + 3'd1;
        end else if (btn_dn && !btn_up) begin
            target_d = (target_q == OFF_M) ? OFF_M : target_q - 3'd1;
        end
`ifdef SMARTAC_ECO_EN
        if (eco && (target_d > MAX_M - 3'd1)) begin
            target_d = MAX_M - 3'd1;
        end
`endif
    end

    // Target register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= OFF_M;
        end else begin
            target_q <= target_d;
        end
    end

    // Leaving OFF is held off while the compressor lockout is still counting.
    assign blocked = (mode_q == OFF_M) && (target_q != OFF_M) && (lock_q != '0);

    // Ramp FSM: one step per visit to S_STEADY, then a dwell; also owns the lockout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_STEADY;
            mode_q  <= OFF_M;
            dwell_q <= '0;
            lock_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (lock_q != '0) begin
                lock_q <= lock_q - 1'b1;
            end
            if (mode_q > MAX_M) begin
                mode_q  <= OFF_M;
                state_q <= S_STEADY;
                dwell_q <= '0;
            end else begin
                case (state_q)
                    S_STEADY: begin
                        if ((target_q != mode_q) && !blocked) begin
                            mode_q  <= step_toward(mode_q, target_q);
                            step_q  <= 1'b1;
                            dwell_q <= DW'(DWELL_CYCLES - 1);
                            state_q <= S_DWELL;
                            if ((mode_q == 3'd1) && (target_q == OFF_M)) begin
                                lock_q <= LW'(MIN_OFF_CYCLES);
                            end
                        end
                    end
                    S_DWELL: begin
                        if (dwell_q == '0) begin
                            state_q <= S_STEADY;
                        end else begin
                            dwell_q <= dwell_q - 1'b1;
                        end
                    end
                    default: state_q <= S_STEADY;
                endcase
            end
        end
    end

    assign mode       = mode_q;
    assign target     = target_q;
    assign step_pulse = step_q;
    assign busy       = (state_q == S_DWELL) || (target_q != mode_q);
    assign lockout    = (lock_q != '0);

endmodule
